// File: rtl/i2c_rd_collector_pkg.sv
// Shared types for the I2C read collector: FSM encoding and FIFO entry layout.
// Entry layout (MSB..LSB): data[7:0], dom, idx, last = 11 bits.
package i2c_rd_collector_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DOM_W  = 1;
  localparam int unsigned IDX_W  = 1;
  localparam int unsigned LAST_W = 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DOM_W-1:0]  dom;
    logic [IDX_W-1:0]  idx;
    logic [LAST_W-1:0] last;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/i2c_rd_fifo.sv
// Synchronous show-ahead FIFO. Head word is combinational (zero when empty);
// a push into a full FIFO is only accepted when a pop happens in the same cycle.
module i2c_rd_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH = 2**PTR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + (PTR_W+1)'(1);
      else if (!do_push && do_pop) level <= level - (PTR_W+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/i2c_rd_collector.sv
// Poll sequencer and byte collector for the I2C world top. Issues a start pulse
// every PERIOD idle cycles (when FIFO space allows), tags returned bytes with
// domain/slave index and streams them out through a show-ahead FIFO.
// Optional watchdog in S_WAIT: define I2C_COLL_TIMEOUT_EN.
module i2c_rd_collector
  import i2c_rd_collector_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PTR_W       = 3,
  parameter int unsigned FRAME_LEN   = 2,
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             domain,
  input  logic             poll_en,
  output logic             start,
  input  logic [7:0]       rd_data,
  input  logic             valid,
  input  logic             done,
  output logic [7:0]       out_data,
  output logic [1:0]       out_tag,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   level,
  output logic [7:0]       drop_cnt,
  output logic             err
);

  localparam int unsigned POLL_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned IDXC_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned LVL_W  = PTR_W + 1;

  // Reject configurations the design cannot honour.
  if (DEPTH < 2 * FRAME_LEN || PERIOD < 2 || TIMEOUT_CYC < 2 || DEPTH != (1 << PTR_W))
  begin : g_bad_cfg
    $error("i2c_rd_collector: illegal parameter combination");
  end

  state_t             state;
  state_t             state_nxt;
  logic [POLL_W-1:0]  poll_cnt;
  logic [IDXC_W-1:0]  idx;
  logic               dom_q;
  logic               space_ok;
  logic               poll_hit;
  logic               fire;
  logic               timeout;
  logic               push_req;
  logic               drop;
  logic               full;
  logic               empty;
  logic               start_nxt;
  entry_t             wr_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] head_raw;

  assign space_ok = (LVL_W'(DEPTH) - level) >= LVL_W'(FRAME_LEN);
  assign poll_hit = (poll_cnt == POLL_W'(PERIOD - 1));
  assign fire     = (state == S_IDLE) && poll_en && poll_hit && space_ok;
  assign push_req = (state == S_WAIT) && valid && (idx < IDXC_W'(FRAME_LEN));
  assign drop     = (valid && !push_req) || (push_req && full && !out_ready);

`ifdef I2C_COLL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt;
  logic            err_nxt;

  assign timeout = (state == S_WAIT) && !done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: cleared on entry to S_WAIT, counts every cycle while waiting.
  always_ff @(posedge clk) begin
    if (rst)                    wd_cnt <= '0;
    else if (fire)              wd_cnt <= '0;
    else if (state == S_WAIT)   wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_nxt;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: poll start leaves idle; done (or watchdog) returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fire) state_nxt = S_WAIT;
      S_WAIT: if (done || timeout) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, registered below.
  always_comb begin
    start_nxt = 1'b0;
`ifdef I2C_COLL_TIMEOUT_EN
    err_nxt   = 1'b0;
`endif
    case (state)
      S_IDLE: start_nxt = fire;
`ifdef I2C_COLL_TIMEOUT_EN
      S_WAIT: err_nxt   = timeout;
`endif
      default: ;
    endcase
  end

  // Start pulse register.
  always_ff @(posedge clk) begin
    if (rst) start <= 1'b0;
    else     start <= start_nxt;
  end

  // Poll counter: runs in idle while enabled, parks at PERIOD-1 until space frees.
  always_ff @(posedge clk) begin
    if (rst)                                   poll_cnt <= '0;
    else if (state != S_IDLE || !poll_en || fire) poll_cnt <= '0;
    else if (!poll_hit)                        poll_cnt <= poll_cnt + POLL_W'(1);
  end

  // Per-frame domain latch and slave index.
  always_ff @(posedge clk) begin
    if (rst) begin
      dom_q <= 1'b0;
      idx   <= '0;
    end else if (fire) begin
      dom_q <= domain;
      idx   <= '0;
    end else if (push_req) begin
      idx   <= idx + IDXC_W'(1);
    end
  end

  // Saturating count of discarded bytes.
  always_ff @(posedge clk) begin
    if (rst)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign wr_entry = '{data: rd_data, dom: dom_q, idx: IDX_W'(idx), last: done};

  i2c_rd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (out_ready),
    .wdata (wr_entry),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head      = entry_t'(head_raw);
  assign out_data  = head.data;
  assign out_tag   = {head.dom, head.idx};
  assign out_last  = head.last;
  assign out_valid = !empty;

endmodule

// File: tb/tb_i2c_rd_collector.sv
// Scoreboard bench for i2c_rd_collector (PERIOD=10, DEPTH=8, TIMEOUT_CYC=50).
module tb_i2c_rd_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       domain;
  logic       poll_en;
  logic       start;
  logic [7:0] rd_data;
  logic       valid;
  logic       done;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;
  logic [7:0] drop_cnt;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  i2c_rd_collector #(
    .DEPTH(8), .PTR_W(3), .FRAME_LEN(2), .PERIOD(10), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .domain(domain), .poll_en(poll_en), .start(start),
    .rd_data(rd_data), .valid(valid), .done(done), .out_data(out_data),
    .out_tag(out_tag), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .drop_cnt(drop_cnt), .err(err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until start is observed; returns max+1 if it never comes.
  task automatic wait_start(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (start !== 1'b1 && n < max);
    if (start !== 1'b1) n = max + 1;
  endtask

  task automatic send(input logic [7:0] d, input logic dn, input logic exp_push, input logic [1:0] tag);
    valid   = 1'b1;
    rd_data = d;
    done    = dn;
    if (exp_push) sb_q.push_back({d, tag, dn});
    tick();
    valid   = 1'b0;
    done    = 1'b0;
    rd_data = 8'h00;
  endtask

  task automatic end_frame();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Monitor: every accepted head entry is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {21'd0, out_data, out_tag, out_last}, 32'hFFFF_FFFF);
      end else begin
        logic [10:0] exp_e;
        exp_e = sb_q.pop_front();
        check("out_entry", {21'd0, out_data, out_tag, out_last}, {21'd0, exp_e});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int cnt;
    rst = 1'b1; domain = 1'b1; poll_en = 1'b1; valid = 1'b0; done = 1'b0;
    rd_data = 8'h00; out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_start", start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_last", out_last, 0);
    check("rst_level", level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err", err, 0);

    // First poll 10 cycles after reset release, then the 2-byte frame
    rst = 1'b0;
    wait_start(20, n);
    check("first_start", n, 10);
    send(8'h12, 1'b0, 1'b1, 2'b10);
    check("start_pulse_width", start, 0);
    send(8'h90, 1'b1, 1'b1, 2'b11);

    // Next poll after 10 idle cycles; domain 0; third byte overflows the frame
    domain = 1'b0;
    wait_start(20, n);
    check("poll_gap", n, 10);
    send(8'h34, 1'b0, 1'b1, 2'b00);
    send(8'h56, 1'b0, 1'b1, 2'b01);
    send(8'h78, 1'b1, 1'b0, 2'b00);
    check("overflow_drop", drop_cnt, 1);
    poll_en = 1'b0;
    repeat (6) tick();
    check("drained_level", level, 0);

    // Back-pressure: four frames fill the FIFO, then polling stalls
    out_ready = 1'b0;
    poll_en   = 1'b1;
    domain    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(20, n);
      check("bp_poll_gap", n, 10);
      send(8'hA0 + 8'(2 * i), 1'b0, 1'b1, 2'b10);
      send(8'hA1 + 8'(2 * i), 1'b1, 1'b1, 2'b11);
    end
    check("full_level", level, 8);
    check("full_no_drop", drop_cnt, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (start === 1'b1) cnt++;
    end
    check("start_suppressed", cnt, 0);
    send(8'hEE, 1'b0, 1'b0, 2'b00);
    check("idle_valid_drop", drop_cnt, 2);
    check("idle_valid_level", level, 8);

    // Two pops free a frame's worth of space; start follows one cycle later
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("level_after_2_pops", level, 6);
    check("no_start_at_7", start, 0);
    tick();
    check("start_resumes", start, 1);
    out_ready = 1'b1;
    send(8'hC1, 1'b0, 1'b1, 2'b10);
    out_ready = 1'b0;
    check("push_pop_level", level, 6);
    send(8'hC2, 1'b1, 1'b1, 2'b11);
    check("push_level", level, 7);
    check("push_pop_no_drop", drop_cnt, 2);

    poll_en   = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("empty_level", level, 0);
    check("empty_out_valid", out_valid, 0);
    check("empty_out_data", out_data, 0);

    // Frame without done
    poll_en = 1'b1;
    wait_start(20, n);
    check("wd_poll_gap", n, 10);
    send(8'h5A, 1'b0, 1'b1, 2'b10);
`ifdef I2C_COLL_TIMEOUT_EN
    cnt = 1;
    while (err !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    check("err_cycle", cnt, 50);
    tick();
    check("err_pulse_width", err, 0);
`else
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (err !== 1'b0) cnt++;
    end
    check("err_tied_low", cnt, 0);
    end_frame();
`endif
    poll_en = 1'b0;
    repeat (5) tick();

    // Reset mid-frame discards buffered bytes and counters
    poll_en   = 1'b1;
    out_ready = 1'b0;
    wait_start(20, n);
    check("pre_rst_poll_gap", n, 10);
    send(8'h77, 1'b0, 1'b1, 2'b10);
    check("pre_rst_level", level, 1);
    check("pre_rst_drop", drop_cnt, 2);
    rst = 1'b1;
    sb_q.delete();
    tick();
    check("midrst_level", level, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_drop", drop_cnt, 0);
    check("midrst_start", start, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_start(20, n);
    check("start_after_rst", n, 10);
    end_frame();
    poll_en = 1'b0;
    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
